line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 200, image width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 200, image height in pixels.
REQ-003 The block SHALL have parameter PIXW, default 8, pixel width in RGB332 format.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (VGA pixel clock domain).
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_pixel is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-008 The block SHALL have port in_sof, input, 1 bit: marks pixel (0,0) of a frame.
REQ-009 The block SHALL have port in_pixel, input, PIXW bits: raster-order pixel.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a window is presented this cycle, with no backpressure.
REQ-011 The block SHALL have port out_win, output, 9*PIXW bits: 3x3 neighbourhood, where slot k occupies bits [PIXW*k+PIXW-1 : PIXW*k], k=0 is top-left, k=4 is the centre, k=8 is bottom-right, in row-major order.
REQ-012 The block SHALL have port out_x, output, 8 bits: column of the window centre.
REQ-013 The block SHALL have port out_y, output, 8 bits: row of the window centre.
REQ-014 The block SHALL have port out_sof, output, 1 bit: high with the window centred at (0,0).
REQ-015 The block SHALL have port out_eof, output, 1 bit: high with the window centred at (WIDTH-1,HEIGHT-1).
REQ-016 The block SHALL have port sof_err, output, 1 bit: one-cycle pulse when in_sof arrives mid-frame.

Function
REQ-017 A pixel SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-018 The block SHALL store two previous rows in two WIDTH-deep line buffers of PIXW bits each, plus a 3x3 shift window.
REQ-019 The state machine SHALL have exactly four states: IDLE, FILL, RUN, FLUSH.
REQ-020 IDLE: in_ready=1; an accepted pixel with in_sof=0 SHALL be discarded; an accepted pixel with in_sof=1 SHALL be stored as (0,0) and the state SHALL go to FILL.
REQ-021 FILL: accepted pixels SHALL be stored with no output; after linear index WIDTH+1 is accepted the state SHALL go to RUN.
REQ-022 RUN: each accepted pixel at linear index n SHALL produce the window centred at index n-WIDTH-1 on the next cycle, i.e. registered with 1-cycle latency.
REQ-023 After index WIDTH*HEIGHT-1 is accepted the state SHALL go to FLUSH.
REQ-024 FLUSH: in_ready=0 for exactly WIDTH+1 cycles; each cycle SHALL inject a zero pseudo-pixel and emit one window; the state SHALL then return to IDLE.
REQ-025 Each frame SHALL produce exactly WIDTH*HEIGHT windows, in raster order of the centre.
REQ-026 Zero-fill: any window slot lying outside the image (row -1, row HEIGHT, column -1, column WIDTH) SHALL read 0.
REQ-027 Zero-fill SHALL also apply at column wrap, so the left neighbour of column 0 is never the previous row's last pixel.
REQ-028 The input column and row counters SHALL wrap column WIDTH-1 to 0 and increment the row; the output centre counters SHALL behave the same way.
REQ-029 in_sof=1 on an accepted pixel in FILL or RUN SHALL pulse sof_err for 1 cycle and restart the frame with that pixel as (0,0) in FILL.
REQ-030 No window from the aborted frame SHALL be emitted after the cycle following the restart.
REQ-031 When in_valid=0 in FILL or RUN, the block SHALL hold all state and keep out_valid=0 on the following cycle.
REQ-032 out_win, out_x and out_y SHALL be don't-care when out_valid=0.
REQ-033 out_sof and out_eof SHALL be 0 whenever out_valid=0.

Reset
REQ-034 While rst=1 at a clk edge, the state SHALL become IDLE and all counters SHALL be cleared.
REQ-035 While rst=1, in_ready, out_valid, out_sof, out_eof and sof_err SHALL be 0, and out_win, out_x and out_y SHALL be 0.
REQ-036 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-037 Reset SHALL take priority over every other event, including mid-FLUSH.
REQ-038 Line buffer contents SHALL NOT be cleared on reset; zero-fill masking SHALL guarantee correct output.

Verification
REQ-039 Ramp frame with in_pixel = x+1 and in_valid held at 1: first out_valid SHALL occur 1 cycle after index 201 is accepted, with out_sof=1 and window (0,0) = 0,0,0,0,1,2,0,1,2; exactly 40000 windows SHALL be emitted.
REQ-040 Same ramp frame: window (199,199) SHALL be 199,200,0,199,200,0,0,0,0 with out_eof=1 on the last FLUSH cycle, and in_ready=0 for exactly 201 cycles after the last pixel.
REQ-041 Same frame with in_valid randomly 50% duty: the window sequence and values SHALL be identical to REQ-039.
REQ-042 Ten pixels with in_sof=0 sent in IDLE, then a normal frame: the output SHALL match REQ-039 exactly.
REQ-043 in_sof asserted at linear index 5000: sof_err SHALL pulse once, and the next out_sof SHALL come 1 cycle after the new frame's index 201 is accepted, with no stale windows in between.
REQ-044 rst=1 for 2 cycles mid-RUN: out_valid=0 and in_ready=0 during reset; in_ready=1 the next cycle; the next frame SHALL be correct per REQ-039.

Source files
------------

// File: rtl/line_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shift window,
// emitting one zero-padded window per pixel in raster order of the centre.
module line_window_buffer #(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 200,
    parameter int PIXW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [PIXW-1:0]   in_pixel,
    output logic              out_valid,
    output logic [9*PIXW-1:0] out_win,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic              out_sof,
    output logic              out_eof,
    output logic              sof_err
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              in_x_q, in_x_d, in_y_q, in_y_d;
    logic [7:0]              cx_q, cx_d, cy_q, cy_d;
    logic [7:0]              ox_q, ox_d, oy_q, oy_d;
    logic                    valid_q, valid_d, osof_q, osof_d, oeof_q, oeof_d;
    logic                    err_q, err_d;
    logic [8:0][PIXW-1:0]    win_q, win_d;
    logic [PIXW-1:0]         lb0_q [WIDTH];
    logic [PIXW-1:0]         lb1_q [WIDTH];

    logic                    ready, accept, advance, sof_start, emit;
    logic [7:0]              col;
    logic [PIXW-1:0]         pix;

    assign accept = in_valid && ready;

    always_comb begin
        state_d   = state_q;
        in_x_d    = in_x_q;
        in_y_d    = in_y_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        valid_d   = 1'b0;
        osof_d    = 1'b0;
        oeof_d    = 1'b0;
        err_d     = 1'b0;
        win_d     = win_q;
        ready     = 1'b0;
        advance   = 1'b0;
        sof_start = 1'b0;
        emit      = 1'b0;
        pix       = in_pixel;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (accept && in_sof) begin
                    advance   = 1'b1;
                    sof_start = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                ready = 1'b1;
                if (accept) begin
                    advance = 1'b1;
                    if (in_sof) begin
                        sof_start = 1'b1;
                        err_d     = 1'b1;
                    end else if (in_x_q == 8'd1 && in_y_q == 8'd1) begin
                        emit    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                ready = 1'b1;
                if (accept) begin
                    advance = 1'b1;
                    if (in_sof) begin
                        sof_start = 1'b1;
                        err_d     = 1'b1;
                        state_d   = FILL;
                    end else begin
                        emit = 1'b1;
                        if (in_x_q == X_LAST && in_y_q == Y_LAST)
                            state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                advance = 1'b1;
                emit    = 1'b1;
                pix     = '0;
                if (cx_q == X_LAST && cy_q == Y_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        col = sof_start ? 8'd0 : in_x_q;

        if (sof_start) begin
            in_x_d = (WIDTH > 1) ? 8'd1 : 8'd0;
            in_y_d = (WIDTH > 1) ? 8'd0 : 8'd1;
            cx_d   = '0;
            cy_d   = '0;
        end else if (advance) begin
            if (in_x_q == X_LAST) begin
                in_x_d = '0;
                in_y_d = in_y_q + 8'd1;
            end else begin
                in_x_d = in_x_q + 8'd1;
            end
        end

        // New right column is {row y-2, row y-1, row y} at the incoming column.
        if (advance) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[r*3]   = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb1_q[col[AW-1:0]];
            win_d[5] = lb0_q[col[AW-1:0]];
            win_d[8] = pix;
        end

        if (emit) begin
            valid_d = 1'b1;
            ox_d    = cx_q;
            oy_d    = cy_q;
            osof_d  = (cx_q == 8'd0) && (cy_q == 8'd0);
            oeof_d  = (cx_q == X_LAST) && (cy_q == Y_LAST);
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? 8'd0 : cy_q + 8'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_x_q  <= '0;
            in_y_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            valid_q <= 1'b0;
            osof_q  <= 1'b0;
            oeof_q  <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            in_x_q  <= in_x_d;
            in_y_q  <= in_y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            valid_q <= valid_d;
            osof_q  <= osof_d;
            oeof_q  <= oeof_d;
            err_q   <= err_d;
            win_q   <= win_d;
        end
    end

    // Line buffers are never cleared; out-of-image slots are masked at the output.
    always_ff @(posedge clk) begin
        if (!rst && advance) begin
            lb1_q[col[AW-1:0]] <= lb0_q[col[AW-1:0]];
            lb0_q[col[AW-1:0]] <= pix;
        end
    end

    always_comb begin
        out_win = '0;
        if (!rst) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    if (!((r == 0 && oy_q == 8'd0) || (r == 2 && oy_q == Y_LAST) ||
                          (c == 0 && ox_q == 8'd0) || (c == 2 && ox_q == X_LAST)))
                        out_win[PIXW*(r*3+c) +: PIXW] = win_q[r*3+c];
                end
            end
        end
    end

    assign in_ready  = ready && !rst;
    assign out_valid = valid_q && !rst;
    assign out_x     = rst ? 8'd0 : ox_q;
    assign out_y     = rst ? 8'd0 : oy_q;
    assign out_sof   = osof_q && !rst;
    assign out_eof   = oeof_q && !rst;
    assign sof_err   = err_q && !rst;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a reduced 8x6 image: ramp and
// row-coded frames, stalled input, pre-frame garbage, mid-frame restart, reset.
module tb_line_window_buffer;

    localparam int W = 8;
    localparam int H = 6;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_sof;
    logic [P-1:0]   in_pixel;
    logic           out_valid;
    logic [9*P-1:0] out_win;
    logic [7:0]     out_x;
    logic [7:0]     out_y;
    logic           out_sof;
    logic           out_eof;
    logic           sof_err;

    int tests  = 0;
    int failed = 0;

    line_window_buffer #(.WIDTH(W), .HEIGHT(H), .PIXW(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
        .out_win  (out_win),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .sof_err  (sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] pixval(input int pat, input int x, input int y);
        if (pat == 0) return P'(x + 1);
        return P'(y * 16 + x + 1);
    endfunction

    function automatic logic [9*P-1:0] exp_win(input int pat, input int cx, input int cy);
        logic [9*P-1:0] w;
        int px, py;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = cx + c - 1;
                py = cy + r - 1;
                if (px >= 0 && px < W && py >= 0 && py < H)
                    w[(r*3+c)*P +: P] = pixval(pat, px, py);
            end
        end
        return w;
    endfunction

    task automatic send_pixels(input int n, input bit sof_first, input int pat);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sof   = sof_first && (i == 0);
            in_pixel = pixval(pat, i % W, (i / W) % H);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int pat, input bit rand_valid, input int exp_err);
        int acc, nwin, ex, ey, cyc, nerr, stall;
        bit first_seen, rdy;
        logic [9*P-1:0] win00, winlast;
        win00   = {8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        winlast = {8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7, 8'd0, 8'd8, 8'd7};
        acc = 0; nwin = 0; ex = 0; ey = 0; cyc = 0; nerr = 0; stall = 0;
        first_seen = 1'b0;
        while (nwin < W*H && cyc < 2000) begin
            if (acc < W*H) begin
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_sof   = (acc == 0);
                in_pixel = pixval(pat, acc % W, acc / W);
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                in_pixel = '0;
            end
            #1;
            rdy = in_ready;
            if (acc == W*H && !rdy) stall++;
            @(posedge clk); #1;
            cyc++;
            if (in_valid && rdy) acc++;
            if (sof_err) nerr++;
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("first_latency", acc, W + 2);
                end
                chk("window", out_win, exp_win(pat, ex, ey));
                chk("meta", {out_x, out_y, out_sof, out_eof},
                    {8'(ex), 8'(ey), (ex == 0 && ey == 0), (ex == W-1 && ey == H-1)});
                if (pat == 0 && ex == 0 && ey == 0) chk("ramp_win_00", out_win, win00);
                if (pat == 0 && ex == W-1 && ey == H-1) chk("ramp_win_last", out_win, winlast);
                nwin++;
                if (ex == W-1) begin ex = 0; ey++; end else ex++;
            end else begin
                chk("idle_flags", {out_sof, out_eof}, 2'b00);
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("window_count", nwin, W*H);
        chk("sof_err_count", nerr, exp_err);
        chk("flush_stall", stall, W + 1);
        chk("ready_after_flush", in_ready, 1'b1);
    endtask

    initial begin
        int nv;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_flags", {out_valid, out_sof, out_eof, sof_err}, 4'b0000);
        chk("rst_data", {out_win, out_x, out_y}, '0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1'b1);

        run_frame(0, 1'b0, 0);
        run_frame(1, 1'b0, 0);
        run_frame(0, 1'b1, 0);

        // Pixels without sof in IDLE are dropped.
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'hAA;
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        in_valid = 1'b0;
        chk("garbage_no_output", nv, 0);
        run_frame(0, 1'b0, 0);

        // Restart mid-frame after 20 pixels.
        send_pixels(20, 1'b1, 1);
        run_frame(1, 1'b0, 1);

        // Reset mid-RUN.
        send_pixels(30, 1'b1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_1", {in_ready, out_valid}, 2'b00);
        @(posedge clk); #1;
        chk("midrst_2", {in_ready, out_valid}, 2'b00);
        rst = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1'b1);
        run_frame(0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
